// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the write arbiter and the register file.
package rf_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;

  // One register-file write request.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way pick between slot A (bit 0) and slot B (bit 1).
// Same-address requests are resolved by age so register writes land in order;
// otherwise the slot not granted most recently wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       same_addr,
  input  logic       older,     // 0: A is older, 1: B is older
  input  logic       last,      // 0: A granted last, 1: B granted last
  output logic [1:0] grant
);

  // Combinational grant: single requester always wins, pair uses age or pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (same_addr) grant = older ? 2'b10 : 2'b01;
        else           grant = last  ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges two write requesters into the single register-file write port.
// Each requester owns a one-entry slot; one full slot is granted per cycle and
// its write is presented on we3/wa3/wd3 combinationally from slot state.
//
// Handshake: a transfer happens at a rising edge of clk where x_valid and
// x_ready are both 1. x_ready depends only on slot state and reset, never on
// x_valid. A transfer to register 0 is accepted and dropped.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0]     wd3,
  output logic [NUM_REGS-1:0]   pending
);

  logic   a_full, b_full;
  rf_wr_t a_q, b_q;
  logic   last_q;   // 1: B granted most recently (so A is favoured)
  logic   older_q;  // 1: B slot is older than A slot

  logic [1:0] req, grant;
  logic       a_load, b_load;

  // No grants while reset is high so a held write is never issued.
  assign req = {b_full, a_full} & {2{~reset}};

  rr_arb2 u_arb (
    .req       (req),
    .same_addr (a_q.addr == b_q.addr),
    .older     (older_q),
    .last      (last_q),
    .grant     (grant)
  );

  assign a_ready = ~reset & (~a_full | grant[0]);
  assign b_ready = ~reset & (~b_full | grant[1]);

  // Register 0 is hardwired zero, so such a handshake never occupies the slot.
  assign a_load = a_valid & a_ready & (a_addr != '0);
  assign b_load = b_valid & b_ready & (b_addr != '0);

  // Write port driven straight from the granted slot.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (grant[0]) begin
      we3 = 1'b1;
      wa3 = a_q.addr;
      wd3 = a_q.data;
    end else if (grant[1]) begin
      we3 = 1'b1;
      wa3 = b_q.addr;
      wd3 = b_q.data;
    end
  end

  // Scoreboard of held destinations; register 0 can never be pending.
  always_comb begin
    pending = '0;
    if (a_full) pending[a_q.addr] = 1'b1;
    if (b_full) pending[b_q.addr] = 1'b1;
    pending[0] = 1'b0;
  end

  // Slot, pointer and age state; a granted slot may reload in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_full  <= 1'b0;
      b_full  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b1;
      older_q <= 1'b0;
    end else begin
      if (a_load) begin
        a_full <= 1'b1;
        a_q    <= '{addr: a_addr, data: a_data};
      end else if (grant[0]) begin
        a_full <= 1'b0;
      end
      if (b_load) begin
        b_full <= 1'b1;
        b_q    <= '{addr: b_addr, data: b_data};
      end else if (grant[1]) begin
        b_full <= 1'b0;
      end
      if (|grant) last_q <= grant[1];
      // A freshly loaded slot is younger than whatever the other slot holds.
      if (a_load && b_load) older_q <= 1'b0;
      else if (a_load)      older_q <= 1'b1;
      else if (b_load)      older_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs driven and outputs checked on the
// falling edge; a write monitor pops expected writes from a queue.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int W = REG_ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                  a_valid, b_valid, a_ready, b_ready, we3;
  logic [REG_ADDR_W-1:0] a_addr, b_addr, wa3;
  logic [DATA_W-1:0]     a_data, b_data, wd3;
  logic [NUM_REGS-1:0]   pending;

  rf_write_arbiter dut (
    .clk (clk), .reset (reset),
    .a_valid (a_valid), .a_ready (a_ready), .a_addr (a_addr), .a_data (a_data),
    .b_valid (b_valid), .b_ready (b_ready), .b_addr (b_addr), .b_data (b_data),
    .we3 (we3), .wa3 (wa3), .wd3 (wd3), .pending (pending)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every issued write must match the next expected write.
  always begin
    @(negedge clk);
    #2;
    if (we3) begin
      if (exp_q.size() == 0) check_eq("spurious_we3", {15'b0, we3}, 16'h0);
      else                   check_eq("wr_addr_data", {5'b0, wa3, wd3}, {5'b0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int a_idx, b_idx;
  logic hs_a, hs_b;

  initial begin
    idle_inputs();
    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_a_ready", {15'b0, a_ready}, 16'h0);
    check_eq("rst_b_ready", {15'b0, b_ready}, 16'h0);
    check_eq("rst_we3", {15'b0, we3}, 16'h0);
    check_eq("rst_pending", {8'b0, pending}, 16'h0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_a_ready", {15'b0, a_ready}, 16'h1);

    // ---- single write ----
    @(negedge clk);
    exp_q.push_back({3'd3, 8'h5A});
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A;
    @(negedge clk);
    a_valid = 1'b0;
    check_eq("single_we3", {15'b0, we3}, 16'h1);
    check_eq("single_wa3", {13'b0, wa3}, 16'h3);
    check_eq("single_wd3", {8'b0, wd3}, 16'h5A);
    check_eq("single_pending", {8'b0, pending}, 16'h08);
    @(negedge clk);
    check_eq("single_pending_clr", {8'b0, pending}, 16'h00);
    check_eq("single_we3_clr", {15'b0, we3}, 16'h0);

    // ---- contention, different addresses ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({3'd1, 8'h10 + 8'(i)});
      exp_q.push_back({3'd2, 8'h20 + 8'(i)});
    end
    a_idx = 0; b_idx = 0;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h10;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h20;
    #1;
    hs_a = a_valid & a_ready;
    hs_b = b_valid & b_ready;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (hs_a) a_idx++;
      if (hs_b) b_idx++;
      a_data = 8'h10 + 8'(a_idx); a_valid = (a_idx < 4);
      b_data = 8'h20 + 8'(b_idx); b_valid = (b_idx < 4);
      check_eq("cont_we3", {15'b0, we3}, 16'h1);
      if (k <= 6) begin
        check_eq("cont_a_ready", {15'b0, a_ready}, {15'b0, k[0]});
        check_eq("cont_b_ready", {15'b0, b_ready}, {15'b0, ~k[0]});
      end
      hs_a = a_valid & a_ready;
      hs_b = b_valid & b_ready;
    end
    @(negedge clk);
    check_eq("cont_drained_we3", {15'b0, we3}, 16'h0);
    check_eq("cont_drained_pending", {8'b0, pending}, 16'h0);

    // ---- same address: age beats a pointer favouring B ----
    do_reset();
    exp_q.push_back({3'd4, 8'h44});
    a_valid = 1'b1; a_addr = 3'd4; a_data = 8'h44;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    exp_q.push_back({3'd5, 8'h11});
    exp_q.push_back({3'd5, 8'h22});
    a_valid = 1'b1; a_addr = 3'd5; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 8'h22;
    @(negedge clk);
    idle_inputs();
    check_eq("same_wd3_first", {8'b0, wd3}, 16'h11);
    check_eq("same_pending", {8'b0, pending}, 16'h20);
    check_eq("same_b_ready", {15'b0, b_ready}, 16'h0);
    @(negedge clk);
    check_eq("same_wd3_second", {8'b0, wd3}, 16'h22);
    @(negedge clk);
    check_eq("same_done_we3", {15'b0, we3}, 16'h0);

    // ---- register 0 ----
    b_valid = 1'b1; b_addr = 3'd0; b_data = 8'hFF;
    #1;
    check_eq("r0_b_ready", {15'b0, b_ready}, 16'h1);
    @(negedge clk);
    b_valid = 1'b0;
    check_eq("r0_we3", {15'b0, we3}, 16'h0);
    check_eq("r0_pending", {8'b0, pending}, 16'h0);
    @(negedge clk);
    check_eq("r0_we3_later", {15'b0, we3}, 16'h0);

    // ---- reset mid-flight ----
    a_valid = 1'b1; a_addr = 3'd6; a_data = 8'h77;
    b_valid = 1'b1; b_addr = 3'd7; b_data = 8'h88;
    @(negedge clk);
    idle_inputs();
    check_eq("mid_pending_full", {8'b0, pending}, 16'hC0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_we3", {15'b0, we3}, 16'h0);
    check_eq("mid_rst_a_ready", {15'b0, a_ready}, 16'h0);
    @(negedge clk);
    check_eq("mid_after_pending", {8'b0, pending}, 16'h0);
    reset = 1'b0;
    #1;
    check_eq("mid_after_a_ready", {15'b0, a_ready}, 16'h1);
    check_eq("mid_after_b_ready", {15'b0, b_ready}, 16'h1);
    @(negedge clk);
    check_eq("mid_after_we3", {15'b0, we3}, 16'h0);

    // ---- back-to-back stream from A ----
    do_reset();
    for (int i = 1; i <= 7; i++) exp_q.push_back({3'(i), 8'hA0 + 8'(i)});
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'hA1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check_eq("b2b_we3", {15'b0, we3}, 16'h1);
      check_eq("b2b_wa3", {13'b0, wa3}, 16'(i));
      check_eq("b2b_a_ready", {15'b0, a_ready}, 16'h1);
      if (i < 7) begin
        a_addr = 3'(i + 1); a_data = 8'hA0 + 8'(i + 1);
      end else begin
        a_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("b2b_end_we3", {15'b0, we3}, 16'h0);

    // ---- final report ----
    @(negedge clk);
    #3;
    check_eq("exp_q_empty", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; reset is sampled on the rising edge of clk.
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- a_valid  input  1  requester A has a write
- a_ready  output  1  A slot can accept
- a_addr  input  3  A destination register
- a_data  input  8  A write data
- b_valid  input  1  requester B has a write
- b_ready  output  1  B slot can accept
- b_addr  input  3  B destination register
- b_data  input  8  B write data
- we3  output  1  register-file write enable
- wa3  output  3  register-file write address
- wd3  output  8  register-file write data
- pending  output  8  bit i = a write to register i is held

Function
REQ-003 Each requester SHALL own a one-entry slot with fields full, addr and data; a handshake occurs at a rising edge where valid and ready are both 1.
REQ-004 A handshake with addr != 0 SHALL load the slot at that edge; a handshake with addr == 0 SHALL complete without loading the slot (register 0 is hardwired zero).
REQ-005 Each cycle the block SHALL grant at most one full slot, and SHALL drive we3=1 with wa3/wd3 from that slot combinationally; with no grant, we3=0 and wa3/wd3=0.
REQ-006 A granted slot SHALL clear at the same edge the register file writes it, so the minimum latency from handshake edge N to register-file write edge is N+1.
REQ-007 x_ready SHALL equal !x_full | x_granted, giving one write per cycle per requester under continuous grants; x_ready SHALL be 0 while reset is 1.
REQ-008 If one slot is full, it SHALL be granted.
REQ-009 If both slots are full with different addr, round-robin SHALL apply: grant the slot not granted most recently; the pointer SHALL update only on a grant.
REQ-010 If both slots are full with equal addr, the older slot SHALL be granted first, regardless of the pointer.
- Age is tracked by one bit; a slot loaded at an edge where the other is already full is younger.
- If both load at the same edge, A is older.
REQ-011 A slot that is granted and reloaded at the same edge SHALL hold the new request and count as younger than the other full slot.
REQ-012 pending[i] SHALL be 1 if and only if a full slot holds addr i; pending[0] SHALL always be 0; pending SHALL be combinational from registered slot state only.
REQ-013 The block SHALL NOT change slot data or addr while the slot is full and not granted.

Reset
REQ-014 Reset SHALL take effect at the edge where it is sampled:
- both slots empty, held requests discarded
- pointer set to favour A
- age bit cleared
- we3=0, wa3=0, wd3=0, pending=0
REQ-015 Reset asserted mid-operation SHALL drop any in-flight slot without issuing its write; the first grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-016 Package rf_pkg SHALL hold:
- REG_ADDR_W=3, DATA_W=8, NUM_REGS=8
- typedef rf_wr_t {addr, data}
This block and the register file SHALL share the package.
REQ-017 The round-robin/age pick SHALL be sub-module rr_arb2: inputs req[1:0], same_addr, older and last; outputs grant[1:0] (one-hot or zero); purely combinational.
REQ-018 All state SHALL live in this module; it SHALL add no pipeline stage between grant and we3/wa3/wd3.

Verification
REQ-019 Single write:
- stimulus: A sends addr 3, data 0x5A at edge 1
- response: cycle 1 has we3=1, wa3=3, wd3=0x5A, pending=0x08; at edge 2, pending=0x00
REQ-020 Contention:
- stimulus: A and B hold valid continuously, A with addr 1, B with addr 2
- response: grants alternate A,B,A,B; each ready pulses every other cycle; no write is lost
REQ-021 Same-address ordering:
- stimulus: A sends r5=0x11 at edge 1; B sends r5=0x22 at edge 1 and the pointer favours B
- response: A is written first, then B; final r5=0x22
REQ-022 Register 0:
- stimulus: B sends addr 0, data 0xFF
- response: b_ready=1, handshake completes, we3 never asserts, pending stays 0x00
REQ-023 Reset mid-flight:
- stimulus: both slots full; reset is sampled for one edge
- response: we3=0 and pending=0 after that edge; no held data is ever written; a_ready=b_ready=1 in the cycle after reset deasserts
REQ-024 Back-to-back:
- stimulus: A streams addr 1..7 with B idle
- response: seven consecutive we3=1 cycles, wa3 = 1..7 in order, a_ready stays 1
